// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial MSB-first pattern transmitter
// with frame repeats, inter-frame gaps, abort and error pulse.
module seq_pattern_tx #(
  parameter int          MAX_LEN     = 16,
  parameter logic [15:0] DEFAULT_PAT = 16'h0009
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [4:0]         len,
  input  logic [3:0]         rpt,
  input  logic [3:0]         gap,
  input  logic               abort,
  output logic               dout,
  output logic               dout_valid,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [MAX_LEN-1:0] ONE = 1;

  state_t r_state, w_state_nx;

  logic [MAX_LEN-1:0] r_pat;
  logic [4:0]         r_len;
  logic [3:0]         r_gap;
  logic [4:0]         r_idx, w_idx_nx;
  logic [3:0]         r_frm, w_frm_nx;
  logic [3:0]         r_gcnt, w_gcnt_nx;
  logic               w_cap;
  logic               w_legal;

  logic [MAX_LEN-1:0] w_pat_nx;
  logic               w_dout_nx;
  logic               w_valid_nx;
  logic               w_busy_nx;
  logic               w_done_nx;
  logic               w_err_nx;

  logic               w_unused;

  assign w_unused = ^DEFAULT_PAT;

  assign w_legal = (len != 5'd0) &&
                   ({27'd0, len} <= MAX_LEN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= 5'd0;
      r_frm   <= 4'd0;
      r_gcnt  <= 4'd0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_frm   <= w_frm_nx;
      r_gcnt  <= w_gcnt_nx;
    end
  end

  // Request values are frozen for the whole transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pat <= '0;
      r_len <= 5'd0;
      r_gap <= 4'd0;
    end else if (w_cap) begin
      r_pat <= pat;
      r_len <= len;
      r_gap <= gap;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_frm_nx   = r_frm;
    w_gcnt_nx  = r_gcnt;
    w_cap      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start && w_legal) begin
          w_cap      = 1'b1;
          w_state_nx = S_SEND;
          w_idx_nx   = len - 5'd1;
          w_frm_nx   = rpt;
        end
      end
      S_SEND: begin
        if (abort) begin
          w_state_nx = S_IDLE;
        end else if (r_idx != 5'd0) begin
          w_idx_nx = r_idx - 5'd1;
        end else if (r_frm == 4'd0) begin
          w_state_nx = S_DONE;
        end else begin
          w_frm_nx = r_frm - 4'd1;
          if (r_gap == 4'd0) begin
            w_idx_nx = r_len - 5'd1;
          end else begin
            w_state_nx = S_GAP;
            w_gcnt_nx  = r_gap - 4'd1;
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          w_state_nx = S_IDLE;
        end else if (r_gcnt == 4'd0) begin
          w_state_nx = S_SEND;
          w_idx_nx   = r_len - 5'd1;
        end else begin
          w_gcnt_nx = r_gcnt - 4'd1;
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they can be registered
  always_comb begin
    w_pat_nx   = w_cap ? pat : r_pat;
    w_valid_nx = (w_state_nx == S_SEND);
    w_dout_nx  = w_valid_nx &
                 (|(w_pat_nx & (ONE << w_idx_nx)));
    w_busy_nx  = w_valid_nx | (w_state_nx == S_GAP);
    w_done_nx  = (w_state_nx == S_DONE);
    w_err_nx   = (r_state == S_IDLE) && start && !w_legal;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      dout       <= w_dout_nx;
      dout_valid <= w_valid_nx;
      busy       <= w_busy_nx;
      done       <= w_done_nx;
      err        <= w_err_nx;
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: directed and randomized checks of seq_pattern_tx
// against a per-transaction expected-trace model.
module tb_seq_pattern_tx;

  localparam int MAXL = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [MAXL-1:0] pat;
  logic [4:0]      len;
  logic [3:0]      rpt;
  logic [3:0]      gap;
  logic            abort;
  logic            dout;
  logic            dout_valid;
  logic            busy;
  logic            done;
  logic            err;

  seq_pattern_tx #(
    .MAX_LEN(MAXL),
    .DEFAULT_PAT(16'h0009)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .pat(pat),
    .len(len),
    .rpt(rpt),
    .gap(gap),
    .abort(abort),
    .dout(dout),
    .dout_valid(dout_valid),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // record = {dout, valid, busy, done, err}
  typedef logic [4:0] rec_t;
  rec_t q[$];
  rec_t cur = 5'd0;

  logic [31:0] bits;
  int          nv;
  int          nd;
  int          ne;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_idle();
    return !cur[2] && !cur[1];
  endfunction

  // Expected trace of a whole transfer built from the request alone
  task automatic model_edge();
    if (is_idle() && start) begin
      if (len >= 5'd1 && int'(len) <= MAXL) begin
        for (int f = 0; f <= int'(rpt); f++) begin
          for (int b = int'(len) - 1; b >= 0; b--)
            q.push_back({pat[b], 4'b1100});
          if (f < int'(rpt))
            for (int k = 0; k < int'(gap); k++)
              q.push_back(5'b00100);
        end
        q.push_back(5'b00010);
      end else begin
        q.push_back(5'b00001);
      end
    end else if (cur[2] && abort) begin
      q.delete();
    end
    cur = (q.size() != 0) ? q.pop_front() : 5'd0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("cycle", {27'd0, dout, dout_valid, busy, done, err},
          {27'd0, cur});
    if (dout_valid) begin
      bits = {bits[30:0], dout};
      nv++;
    end
    if (done) nd++;
    if (err) ne++;
  endtask

  task automatic clr_obs();
    bits = 32'd0;
    nv   = 0;
    nd   = 0;
    ne   = 0;
  endtask

  task automatic send(input logic [15:0] p, input logic [4:0] l,
                      input logic [3:0] r, input logic [3:0] g);
    clr_obs();
    pat   = p;
    len   = l;
    rpt   = r;
    gap   = g;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 600 && !is_idle(); n++) tick();
    if (!is_idle()) check("timeout", 32'd1, 32'd0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    pat   = '0;
    len   = 5'd0;
    rpt   = 4'd0;
    gap   = 4'd0;
    #2;
    check("reset", {27'd0, dout, dout_valid, busy, done, err}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    send(16'h0009, 5'd4, 4'd0, 4'd0);
    check("f1001_bits", bits & 32'hF, 32'h9);
    check("f1001_nv", nv, 4);
    check("f1001_done", nd, 1);

    send(16'h0009, 5'd4, 4'd1, 4'd2);
    check("rpt_gap_bits", bits & 32'hFF, 32'h99);
    check("rpt_gap_nv", nv, 8);
    check("rpt_gap_done", nd, 1);

    send(16'h0009, 5'd0, 4'd0, 4'd0);
    check("len0_err", ne, 1);
    check("len0_nv", nv, 0);
    check("len0_done", nd, 0);

    send(16'h0009, 5'd17, 4'd0, 4'd0);
    check("len17_err", ne, 1);
    check("len17_nv", nv, 0);

    send(16'hA5C3, 5'd16, 4'd0, 4'd0);
    check("len16_bits", bits & 32'hFFFF, 32'hA5C3);
    check("len16_nv", nv, 16);

    send(16'h3, 5'd1, 4'd2, 4'd0);
    check("len1_bits", bits & 32'h7, 32'h7);
    check("len1_nv", nv, 3);

    send(16'h8001, 5'd16, 4'd15, 4'd15);
    check("max_nv", nv, 256);
    check("max_done", nd, 1);

    // abort on the second bit of a frame
    clr_obs();
    pat   = 16'h000B;
    len   = 5'd4;
    rpt   = 4'd0;
    gap   = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid", {31'd0, dout_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    tick();
    tick();
    check("abort_nodone", nd, 0);
    send(16'h0009, 5'd4, 4'd0, 4'd0);
    check("post_abort_bits", bits & 32'hF, 32'h9);

    // start ignored while busy, then async reset mid-frame
    clr_obs();
    pat   = 16'h00F0;
    len   = 5'd8;
    rpt   = 4'd1;
    gap   = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    pat   = 16'h0000;
    len   = 5'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("busy_start_bits", bits & 32'h1F, 32'h1E);
    #3 rst = 1'b1;
    #1;
    check("rst_async", {27'd0, dout, dout_valid, busy, done, err},
          32'd0);
    q.delete();
    cur = 5'd0;
    @(posedge clk);
    #1;
    check("rst_hold", {27'd0, dout, dout_valid, busy, done, err},
          32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    check("rst_nodone", nd, 0);
    send(16'h0009, 5'd4, 4'd0, 4'd0);
    check("post_rst_bits", bits & 32'hF, 32'h9);

    // randomized transfers with stray starts and aborts
    for (int i = 0; i < 40; i++) begin
      pat   = 16'($urandom);
      len   = 5'($urandom_range(0, 20));
      rpt   = 4'($urandom_range(0, 3));
      gap   = 4'($urandom_range(0, 3));
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; n < 600 && !is_idle(); n++) begin
        abort = ($urandom_range(0, 39) == 0);
        start = ($urandom_range(0, 4) == 0);
        pat   = 16'($urandom);
        len   = 5'($urandom_range(0, 20));
        tick();
      end
      if (!is_idle()) check("rand_timeout", 32'd1, 32'd0);
      abort = 1'b0;
      start = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
